// File: rtl/masc_exec_issue.sv
`default_nettype none
// ============================================================================
// Module   : masc_exec_issue
// Purpose  : Issue/collect front end for the masc execute crypto unit.
//            Queues core requests, issues one per cycle to execute, and
//            collects flagged results into an in-order response queue.
//            Issue credits keep the response queue from overflowing.
//            A watchdog reclaims credits when a result never arrives.
// Revision : 1.0 - initial release
// ============================================================================
module masc_exec_issue #(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_instruction,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [7:0]  req_bs,
    output logic [31:0] exe_instruction,
    output logic [31:0] exe_rs1,
    output logic [31:0] exe_rs2,
    output logic [7:0]  exe_bs,
    output logic        exe_valid,
    input  logic [32:0] exe_out,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        busy,
    output logic        err
);

    localparam int c_OP_W  = 104;
    localparam int c_RQ_AW = $clog2(REQ_DEPTH);
    localparam int c_RQ_CW = $clog2(REQ_DEPTH + 1);
    localparam int c_RS_AW = $clog2(RSP_DEPTH);
    localparam int c_RS_CW = $clog2(RSP_DEPTH + 1);
    localparam int c_TW    = $clog2(TIMEOUT);

    // Request queue storage and bookkeeping
    logic [c_OP_W-1:0]  r_req_mem [REQ_DEPTH];
    logic [c_RQ_AW-1:0] r_req_wr;
    logic [c_RQ_AW-1:0] r_req_rd;
    logic [c_RQ_CW-1:0] r_req_count;

    // Response queue storage and bookkeeping
    logic [31:0]        r_rsp_mem [RSP_DEPTH];
    logic [c_RS_AW-1:0] r_rsp_wr;
    logic [c_RS_AW-1:0] r_rsp_rd;
    logic [c_RS_CW-1:0] r_rsp_count;

    logic [c_RS_CW-1:0] r_inflight;
    logic [c_TW-1:0]    r_timer;
    logic [31:0]        r_exe_instruction;
    logic [31:0]        r_exe_rs1;
    logic [31:0]        r_exe_rs2;
    logic [7:0]         r_exe_bs;
    logic               r_exe_valid;
    logic               r_err;

    logic               w_req_full;
    logic               w_req_push;
    logic               w_issue;
    logic [c_RS_CW-1:0] w_credits;
    logic               w_capture;
    logic               w_unexpected;
    logic               w_rsp_pop;
    logic               w_timeout;
    logic [c_OP_W-1:0]  w_req_head;

    // Credits count response slots not yet claimed by an issued op or a held result
    assign w_credits    = c_RS_CW'(RSP_DEPTH) - r_inflight - r_rsp_count;
    assign w_req_full   = (r_req_count == c_RQ_CW'(REQ_DEPTH));
    // Ready is masked during reset so the port reads 0 while reset is held
    assign req_ready    = !w_req_full && !reset;
    assign w_req_push   = req_valid && req_ready;
    assign w_issue      = (r_req_count != '0) && (w_credits != '0);
    assign w_capture    = exe_out[32] && (r_inflight != '0);
    assign w_unexpected = exe_out[32] && (r_inflight == '0);
    assign w_rsp_pop    = rsp_valid && rsp_ready;
    assign w_timeout    = !w_issue && !w_capture && (r_inflight != '0)
                          && (r_timer == c_TW'(TIMEOUT - 1));
    assign w_req_head   = r_req_mem[r_req_rd];

    // Request payload storage, written on accept
    always_ff @(posedge clk) begin
        if (w_req_push) begin
            r_req_mem[r_req_wr] <= {req_instruction, req_rs1, req_rs2, req_bs};
        end
    end

    // Request queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_wr    <= '0;
            r_req_rd    <= '0;
            r_req_count <= '0;
        end else begin
            if (w_req_push) r_req_wr <= r_req_wr + c_RQ_AW'(1);
            if (w_issue)    r_req_rd <= r_req_rd + c_RQ_AW'(1);
            case ({w_req_push, w_issue})
                2'b10:   r_req_count <= r_req_count + c_RQ_CW'(1);
                2'b01:   r_req_count <= r_req_count - c_RQ_CW'(1);
                default: r_req_count <= r_req_count;
            endcase
        end
    end

    // Execute-side registers: exe_valid pulses per issue, payload holds between issues
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exe_instruction <= '0;
            r_exe_rs1         <= '0;
            r_exe_rs2         <= '0;
            r_exe_bs          <= '0;
            r_exe_valid       <= 1'b0;
        end else begin
            r_exe_valid <= w_issue;
            if (w_issue) begin
                r_exe_instruction <= w_req_head[103:72];
                r_exe_rs1         <= w_req_head[71:40];
                r_exe_rs2         <= w_req_head[39:8];
                r_exe_bs          <= w_req_head[7:0];
            end
        end
    end

    // Response payload storage, written on result capture
    always_ff @(posedge clk) begin
        if (w_capture) begin
            r_rsp_mem[r_rsp_wr] <= exe_out[31:0];
        end
    end

    // Response queue pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rsp_wr    <= '0;
            r_rsp_rd    <= '0;
            r_rsp_count <= '0;
        end else begin
            if (w_capture) r_rsp_wr <= r_rsp_wr + c_RS_AW'(1);
            if (w_rsp_pop) r_rsp_rd <= r_rsp_rd + c_RS_AW'(1);
            case ({w_capture, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + c_RS_CW'(1);
                2'b01:   r_rsp_count <= r_rsp_count - c_RS_CW'(1);
                default: r_rsp_count <= r_rsp_count;
            endcase
        end
    end

    // Outstanding-op count, watchdog timer and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inflight <= '0;
            r_timer    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_timeout) begin
                r_inflight <= '0;
            end else begin
                case ({w_issue, w_capture})
                    2'b10:   r_inflight <= r_inflight + c_RS_CW'(1);
                    2'b01:   r_inflight <= r_inflight - c_RS_CW'(1);
                    default: r_inflight <= r_inflight;
                endcase
            end
            if (w_issue || w_capture || w_timeout || (r_inflight == '0)) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + c_TW'(1);
            end
            if (w_timeout || w_unexpected) begin
                r_err <= 1'b1;
            end
        end
    end

    assign exe_instruction = r_exe_instruction;
    assign exe_rs1         = r_exe_rs1;
    assign exe_rs2         = r_exe_rs2;
    assign exe_bs          = r_exe_bs;
    assign exe_valid       = r_exe_valid;
    assign rsp_valid       = (r_rsp_count != '0);
    assign rsp_data        = rsp_valid ? r_rsp_mem[r_rsp_rd] : 32'h0;
    assign busy            = (r_req_count != '0) || (r_rsp_count != '0) || (r_inflight != '0);
    assign err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_masc_exec_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_masc_exec_issue
// Purpose  : Self-checking bench for masc_exec_issue: table-driven single ops,
//            directed multi-cycle corner cases and a randomized run against a
//            queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_masc_exec_issue;

    localparam int REQ_DEPTH = 4;
    localparam int RSP_DEPTH = 4;
    localparam int TIMEOUT   = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_instruction = '0;
    logic [31:0] req_rs1 = '0;
    logic [31:0] req_rs2 = '0;
    logic [7:0]  req_bs = '0;
    logic [31:0] exe_instruction;
    logic [31:0] exe_rs1;
    logic [31:0] exe_rs2;
    logic [7:0]  exe_bs;
    logic        exe_valid;
    logic [32:0] exe_out = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic        busy;
    logic        err;

    masc_exec_issue #(.REQ_DEPTH(REQ_DEPTH), .RSP_DEPTH(RSP_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_instruction(req_instruction), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_bs(req_bs),
        .exe_instruction(exe_instruction), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2), .exe_bs(exe_bs),
        .exe_valid(exe_valid), .exe_out(exe_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [7:0]  bs;
    } op_t;

    typedef struct {
        op_t         op;
        logic [31:0] result;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model state
    op_t         m_req_q[$];
    op_t         m_iss_q[$];
    logic [31:0] m_rsp_q[$];
    op_t         m_exe = '0;
    bit          m_exe_valid = 0;
    bit          m_err = 0;
    int          m_timer = 0;
    bit          m_acc = 0;

    // Bench-side stimulus/observation
    op_t         send_q[$];
    logic [31:0] got_q[$];
    bit          auto_exe = 0;
    int          n_issue = 0;
    int          cyc = 0;

    function automatic logic [31:0] exe_fn(op_t o);
        return o.instr ^ (o.rs1 + o.rs2) ^ {24'h0, o.bs};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Next state of the model from the inputs about to be sampled
    task automatic model_next();
        int nreq;
        int ninf;
        int nrsp;
        bit iss;
        bit cap;
        if (reset) begin
            m_req_q.delete(); m_iss_q.delete(); m_rsp_q.delete();
            m_exe = '0; m_exe_valid = 0; m_err = 0; m_timer = 0; m_acc = 0;
            return;
        end
        nreq  = m_req_q.size();
        ninf  = m_iss_q.size();
        nrsp  = m_rsp_q.size();
        m_acc = req_valid && (nreq < REQ_DEPTH);
        iss   = (nreq > 0) && ((RSP_DEPTH - ninf - nrsp) > 0);
        cap   = exe_out[32] && (ninf > 0);
        if (exe_out[32] && ninf == 0) m_err = 1;
        if (rsp_ready && nrsp > 0) m_rsp_q.delete(0);
        if (cap) begin
            m_iss_q.delete(0);
            m_rsp_q.push_back(exe_out[31:0]);
        end
        if (iss) begin
            m_exe = m_req_q[0];
            m_req_q.delete(0);
            m_iss_q.push_back(m_exe);
        end
        m_exe_valid = iss;
        if (m_acc) m_req_q.push_back({req_instruction, req_rs1, req_rs2, req_bs});
        if (iss || cap) begin
            m_timer = 0;
        end else if (ninf > 0) begin
            if (m_timer == TIMEOUT - 1) begin
                m_err = 1;
                m_iss_q.delete();
                m_timer = 0;
            end else begin
                m_timer++;
            end
        end
    endtask

    task automatic check_model();
        chk("mdl_req_ready", req_ready, !reset && (m_req_q.size() < REQ_DEPTH));
        chk("mdl_exe_valid", exe_valid, m_exe_valid);
        chk("mdl_exe_instruction", exe_instruction, m_exe.instr);
        chk("mdl_exe_rs1", exe_rs1, m_exe.rs1);
        chk("mdl_exe_rs2", exe_rs2, m_exe.rs2);
        chk("mdl_exe_bs", exe_bs, m_exe.bs);
        chk("mdl_rsp_valid", rsp_valid, m_rsp_q.size() > 0);
        chk("mdl_rsp_data", rsp_data, (m_rsp_q.size() > 0) ? m_rsp_q[0] : 32'h0);
        chk("mdl_busy", busy, (m_req_q.size() + m_iss_q.size() + m_rsp_q.size()) > 0);
        chk("mdl_err", err, m_err);
    endtask

    // One clock: drive inputs, advance model, sample after the edge
    task automatic step();
        if (send_q.size() > 0) begin
            req_valid = 1'b1;
            {req_instruction, req_rs1, req_rs2, req_bs} = send_q[0];
        end else begin
            req_valid = 1'b0;
        end
        if (auto_exe) exe_out = m_exe_valid ? {1'b1, exe_fn(m_exe)} : 33'h0;
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) got_q.push_back(rsp_data);
        model_next();
        if (m_acc) send_q.delete(0);
        @(posedge clk);
        #1;
        cyc++;
        check_model();
        if (exe_valid === 1'b1) n_issue++;
    endtask

    task automatic do_reset();
        reset = 1'b1; send_q.delete(); got_q.delete();
        exe_out = '0; rsp_ready = 1'b0; auto_exe = 0;
        step(); step();
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", err, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_release_req_ready", req_ready, 1'b1);
    endtask

    function automatic op_t rand_op();
        op_t o;
        o.instr = $urandom; o.rs1 = $urandom; o.rs2 = $urandom; o.bs = 8'($urandom);
        return o;
    endfunction

    initial begin
        #10_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[5];
        op_t  ops[10];
        int   t0;
        int   first_iss;
        int   last_iss;
        vecs[0].op = {32'd5, 32'd1, 32'd1, 8'd0};                         vecs[0].result = 32'h2;
        vecs[1].op = {32'hFFFF_FFFF, 32'h0, 32'h0, 8'hFF};                vecs[1].result = 32'hDEAD_BEEF;
        vecs[2].op = {32'h0, 32'h0, 32'h0, 8'h00};                        vecs[2].result = 32'h0;
        vecs[3].op = {32'h1234_5678, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 8'h80}; vecs[3].result = 32'hFFFF_FFFF;
        vecs[4].op = {32'h8000_0000, 32'h1, 32'h2, 8'h3};                 vecs[4].result = 32'h0000_0001;

        // Table-driven single ops: latency, hold, capture, response stability
        do_reset();
        foreach (vecs[i]) begin
            send_q.push_back(vecs[i].op);
            step();
            chk("v_accept_no_issue", exe_valid, 1'b0);
            chk("v_accept_busy", busy, 1'b1);
            step();
            chk("v_issue_valid", exe_valid, 1'b1);
            chk("v_issue_instr", exe_instruction, vecs[i].op.instr);
            chk("v_issue_rs1", exe_rs1, vecs[i].op.rs1);
            chk("v_issue_rs2", exe_rs2, vecs[i].op.rs2);
            chk("v_issue_bs", exe_bs, vecs[i].op.bs);
            step();
            chk("v_pulse_end", exe_valid, 1'b0);
            chk("v_hold_instr", exe_instruction, vecs[i].op.instr);
            exe_out = {1'b1, vecs[i].result};
            step();
            exe_out = '0;
            chk("v_rsp_valid", rsp_valid, 1'b1);
            chk("v_rsp_data", rsp_data, vecs[i].result);
            step();
            chk("v_rsp_stable", rsp_data, vecs[i].result);
            rsp_ready = 1'b1;
            step();
            rsp_ready = 1'b0;
            chk("v_rsp_popped", rsp_valid, 1'b0);
            chk("v_idle_busy", busy, 1'b0);
        end

        // Back-to-back with a 1-cycle execute model
        do_reset();
        rsp_ready = 1'b1; auto_exe = 1; n_issue = 0; first_iss = -1; last_iss = -1;
        for (int i = 0; i < 4; i++) begin ops[i] = rand_op(); send_q.push_back(ops[i]); end
        for (int k = 0; k < 14; k++) begin
            step();
            if (exe_valid === 1'b1) begin
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
            end
        end
        chk("b2b_issues", n_issue, 4);
        chk("b2b_consecutive", last_iss - first_iss, 3);
        chk("b2b_rsp_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("b2b_rsp_order", got_q[i], exe_fn(ops[i]));
        chk("b2b_busy_end", busy, 1'b0);

        // Backpressure: credits stop issue at RSP_DEPTH, then drain in order
        do_reset();
        auto_exe = 1; n_issue = 0;
        for (int i = 0; i < 10; i++) begin ops[i] = rand_op(); send_q.push_back(ops[i]); end
        for (int k = 0; k < 20; k++) step();
        chk("bp_issues", n_issue, 4);
        chk("bp_req_ready", req_ready, 1'b0);
        chk("bp_pending_sends", send_q.size(), 2);
        chk("bp_rsp_valid", rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        t0 = 0;
        while (got_q.size() < 10 && t0 < 100) begin step(); t0++; end
        chk("bp_drain_count", got_q.size(), 10);
        for (int i = 0; i < 10 && i < got_q.size(); i++) chk("bp_rsp_order", got_q[i], exe_fn(ops[i]));
        for (int k = 0; k < 3; k++) step();
        chk("bp_busy_end", busy, 1'b0);

        // Watchdog: no result for TIMEOUT cycles after issue
        do_reset();
        rsp_ready = 1'b1;
        send_q.push_back(rand_op());
        step();
        step();
        chk("to_issue", exe_valid, 1'b1);
        for (int k = 1; k < TIMEOUT; k++) begin
            step();
            chk("to_err_early", err, 1'b0);
        end
        step();
        chk("to_err_set", err, 1'b1);
        chk("to_inflight_cleared", busy, 1'b0);
        exe_out = {1'b1, 32'hCAFE_0001};
        step();
        exe_out = '0;
        chk("to_late_err", err, 1'b1);
        chk("to_late_dropped", rsp_valid, 1'b0);
        n_issue = 0;
        for (int i = 0; i < 4; i++) send_q.push_back(rand_op());
        for (int k = 0; k < 6; k++) step();
        chk("to_credits_restored", n_issue, 4);
        for (int k = 0; k < 12; k++) step();

        // Unexpected result while idle
        do_reset();
        step();
        exe_out = {1'b1, 32'h0000_1234};
        step();
        exe_out = '0;
        chk("unexp_err", err, 1'b1);
        chk("unexp_rsp_valid", rsp_valid, 1'b0);
        step();
        chk("unexp_rsp_valid_later", rsp_valid, 1'b0);

        // Reset with work queued, inflight and held
        do_reset();
        auto_exe = 1;
        send_q.push_back(rand_op()); send_q.push_back(rand_op());
        for (int k = 0; k < 4; k++) step();
        auto_exe = 0; exe_out = '0;
        for (int i = 0; i < 5; i++) send_q.push_back(rand_op());
        for (int k = 0; k < 5; k++) step();
        chk("mid_busy", busy, 1'b1);
        chk("mid_rsp_valid", rsp_valid, 1'b1);
        reset = 1'b1; send_q.delete();
        step();
        chk("mid_rst_req_ready", req_ready, 1'b0);
        chk("mid_rst_exe_valid", exe_valid, 1'b0);
        chk("mid_rst_exe_instr", exe_instruction, 32'h0);
        chk("mid_rst_rsp_valid", rsp_valid, 1'b0);
        chk("mid_rst_rsp_data", rsp_data, 32'h0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_err", err, 1'b0);
        reset = 1'b0;
        exe_out = {1'b1, 32'h5555_AAAA};
        step();
        exe_out = '0;
        chk("mid_post_err", err, 1'b1);
        chk("mid_post_rsp_valid", rsp_valid, 1'b0);
        chk("mid_post_exe_valid", exe_valid, 1'b0);
        step();
        chk("mid_post_exe_valid2", exe_valid, 1'b0);
        chk("mid_post_busy", busy, 1'b0);

        // Randomized run against the reference model
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            int bias;
            bias = ((k / 300) % 2 == 0) ? 6 : 2;
            if (send_q.size() < 3 && ($urandom % 10) < 6) send_q.push_back(rand_op());
            rsp_ready = (($urandom % 10) < bias);
            if (m_iss_q.size() > 0 && ($urandom % 10) < 7) exe_out = {1'b1, exe_fn(m_iss_q[0])};
            else exe_out = {1'b0, 32'($urandom)};
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
